// File: rtl/morse_tx_sequencer.sv
// Morse transmit sequencer: accepts ASCII over valid/ready and keys timed
// Morse on key_out, one unit = UNIT_CYCLES clocks.
// Optional build macro MORSE_ABORT_EN adds a synchronous abort input that
// cuts the current character short and finishes with a character gap.

// Character to Morse code table. The 24-bit code is eight 3-bit groups,
// MSB first: bit2 = last group, bit1 = element present, bit0 = dash.
module morse_lut (
  input  logic [7:0]  ascii,
  output logic [23:0] code
);

  logic [7:0] upper;
  logic [3:0] len;
  logic [7:0] pat;
  logic       is_space;
  logic [7:0] bits;
  logic [2:0] grp;

  // Fold lowercase onto uppercase so both key identically
  always_comb begin
    upper = ascii;
    if (ascii >= 8'h61 && ascii <= 8'h7A) upper = ascii - 8'h20;
  end

  // Element count and dash mask (1 = dash), first element in bit len-1;
  // anything not listed falls back to the 8-dot error code
  always_comb begin
    len      = 4'd8;
    pat      = 8'b0000_0000;
    is_space = 1'b0;
    case (upper)
      8'h20: is_space = 1'b1;
      8'h41: begin len = 4'd2; pat = 8'b0000_0001; end // A .-
      8'h42: begin len = 4'd4; pat = 8'b0000_1000; end // B -...
      8'h43: begin len = 4'd4; pat = 8'b0000_1010; end // C -.-.
      8'h44: begin len = 4'd3; pat = 8'b0000_0100; end // D -..
      8'h45: begin len = 4'd1; pat = 8'b0000_0000; end // E .
      8'h46: begin len = 4'd4; pat = 8'b0000_0010; end // F ..-.
      8'h47: begin len = 4'd3; pat = 8'b0000_0110; end // G --.
      8'h48: begin len = 4'd4; pat = 8'b0000_0000; end // H ....
      8'h49: begin len = 4'd2; pat = 8'b0000_0000; end // I ..
      8'h4A: begin len = 4'd4; pat = 8'b0000_0111; end // J .---
      8'h4B: begin len = 4'd3; pat = 8'b0000_0101; end // K -.-
      8'h4C: begin len = 4'd4; pat = 8'b0000_0100; end // L .-..
      8'h4D: begin len = 4'd2; pat = 8'b0000_0011; end // M --
      8'h4E: begin len = 4'd2; pat = 8'b0000_0010; end // N -.
      8'h4F: begin len = 4'd3; pat = 8'b0000_0111; end // O ---
      8'h50: begin len = 4'd4; pat = 8'b0000_0110; end // P .--.
      8'h51: begin len = 4'd4; pat = 8'b0000_1101; end // Q --.-
      8'h52: begin len = 4'd3; pat = 8'b0000_0010; end // R .-.
      8'h53: begin len = 4'd3; pat = 8'b0000_0000; end // S ...
      8'h54: begin len = 4'd1; pat = 8'b0000_0001; end // T -
      8'h55: begin len = 4'd3; pat = 8'b0000_0001; end // U ..-
      8'h56: begin len = 4'd4; pat = 8'b0000_0001; end // V ...-
      8'h57: begin len = 4'd3; pat = 8'b0000_0011; end // W .--
      8'h58: begin len = 4'd4; pat = 8'b0000_1001; end // X -..-
      8'h59: begin len = 4'd4; pat = 8'b0000_1011; end // Y -.--
      8'h5A: begin len = 4'd4; pat = 8'b0000_1100; end // Z --..
      8'h30: begin len = 4'd5; pat = 8'b0001_1111; end // 0 -----
      8'h31: begin len = 4'd5; pat = 8'b0000_1111; end // 1 .----
      8'h32: begin len = 4'd5; pat = 8'b0000_0111; end // 2 ..---
      8'h33: begin len = 4'd5; pat = 8'b0000_0011; end // 3 ...--
      8'h34: begin len = 4'd5; pat = 8'b0000_0001; end // 4 ....-
      8'h35: begin len = 4'd5; pat = 8'b0000_0000; end // 5 .....
      8'h36: begin len = 4'd5; pat = 8'b0001_0000; end // 6 -....
      8'h37: begin len = 4'd5; pat = 8'b0001_1000; end // 7 --...
      8'h38: begin len = 4'd5; pat = 8'b0001_1100; end // 8 ---..
      8'h39: begin len = 4'd5; pat = 8'b0001_1110; end // 9 ----.
      8'h2E: begin len = 4'd6; pat = 8'b0001_0101; end // . .-.-.-
      8'h2C: begin len = 4'd6; pat = 8'b0011_0011; end // , --..--
      8'h3F: begin len = 4'd6; pat = 8'b0000_1100; end // ? ..--..
      8'h2F: begin len = 4'd5; pat = 8'b0001_0010; end // / -..-.
      8'h3D: begin len = 4'd5; pat = 8'b0001_0001; end // = -...-
      8'h2D: begin len = 4'd6; pat = 8'b0010_0001; end // - -....-
      8'h27: begin len = 4'd6; pat = 8'b0001_1110; end // ' .----.
      8'h3A: begin len = 4'd6; pat = 8'b0011_1000; end // : ---...
      8'h2B: begin len = 4'd5; pat = 8'b0000_1010; end // + .-.-.
      8'h40: begin len = 4'd6; pat = 8'b0001_1010; end // @ .--.-.
      default: begin len = 4'd8; pat = 8'b0000_0000; end
    endcase
  end

  // Pack the element list into 3-bit groups, first element in the top group
  always_comb begin
    code = 24'h000000;
    bits = pat << (4'd8 - len);
    grp  = 3'b000;
    if (is_space) begin
      code = 24'h800000;
    end else begin
      for (int i = 0; i < 8; i++) begin
        grp = 3'b000;
        if (i < int'(len)) grp = {(i == int'(len) - 1), 1'b1, bits[7]};
        bits = {bits[6:0], 1'b0};
        code = {code[20:0], grp};
      end
    end
  end

endmodule

// Sequencer: IDLE accepts, LOAD fetches the code, MARK/SPACE_GAP walk the
// groups, CHAR_GAP/WORD_GAP hold the key off before returning to IDLE.
module morse_tx_sequencer #(
  parameter int UNIT_CYCLES      = 1000,
  parameter int WORD_EXTRA_UNITS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] ascii_data,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  output logic       key_out,
  output logic       busy,
  output logic       char_done
`ifdef MORSE_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam int MAX_UNITS = (WORD_EXTRA_UNITS > 8) ? WORD_EXTRA_UNITS : 8;
  localparam int CW        = (MAX_UNITS * UNIT_CYCLES > 1) ? $clog2(MAX_UNITS * UNIT_CYCLES) : 1;

  // Counter reload values are duration minus one; the state ends when it hits zero
  localparam logic [CW-1:0] ONE_UNIT    = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] THREE_UNITS = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] WORD_UNITS  = CW'(WORD_EXTRA_UNITS * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MARK,
    SPACE_GAP,
    CHAR_GAP,
    WORD_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [23:0]   shreg_q, shreg_d;
  logic [7:0]    char_q, char_d;
  logic          key_d;
  logic          done_d;
  logic [23:0]   lut_code;
  logic          abort_hit;

  morse_lut u_lut (
    .ascii (char_q),
    .code  (lut_code)
  );

`ifdef MORSE_ABORT_EN
  // Abort only matters while the character is still being keyed
  always_comb begin
    abort_hit = abort && (state_q == LOAD || state_q == MARK || state_q == SPACE_GAP);
  end
`else
  assign abort_hit = 1'b0;
`endif

  assign ascii_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);

  // Next-state, counter reload and shift logic; key follows MARK one clock late
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    char_d  = char_q;
    done_d  = 1'b0;
    key_d   = (state_q == MARK);

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (ascii_valid) begin
          char_d  = ascii_data;
          state_d = LOAD;
        end
      end

      LOAD: begin
        shreg_d = lut_code;
        if (lut_code[22]) begin
          state_d = MARK;
          cnt_d   = lut_code[21] ? THREE_UNITS : ONE_UNIT;
        end else begin
          state_d = WORD_GAP;
          cnt_d   = WORD_UNITS;
        end
      end

      MARK: begin
        if (cnt_q == '0) begin
          if (shreg_q[23]) begin
            state_d = CHAR_GAP;
            cnt_d   = THREE_UNITS;
          end else begin
            shreg_d = {shreg_q[20:0], 3'b000};
            state_d = SPACE_GAP;
            cnt_d   = ONE_UNIT;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      SPACE_GAP: begin
        if (cnt_q == '0) begin
          if (shreg_q[22]) begin
            state_d = MARK;
            cnt_d   = shreg_q[21] ? THREE_UNITS : ONE_UNIT;
          end else begin
            state_d = CHAR_GAP;
            cnt_d   = THREE_UNITS;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      CHAR_GAP, WORD_GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    if (abort_hit) begin
      state_d = CHAR_GAP;
      cnt_d   = THREE_UNITS;
      key_d   = 1'b0;
    end
  end

  // State, timing and registered outputs; reset drops the key immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      char_q    <= '0;
      key_out   <= 1'b0;
      char_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      char_q    <= char_d;
      key_out   <= key_d;
      char_done <= done_d;
    end
  end

endmodule

// File: tb/tb_morse_tx_sequencer.sv
// Self-checking bench for morse_tx_sequencer with UNIT_CYCLES=4.
// Build with MORSE_ABORT_EN defined to also exercise the abort input.
module tb_morse_tx_sequencer;

  localparam int UNIT  = 4;
  localparam int WORDX = 4;
  localparam int NVEC  = 12;

  logic       clk;
  logic       rst_n;
  logic [7:0] ascii_data;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       key_out;
  logic       busy;
  logic       char_done;
`ifdef MORSE_ABORT_EN
  logic       abort;
`endif

  typedef struct {
    logic [7:0]  ch;
    logic [63:0] pat;
    int          expDone;
  } vec_t;

  vec_t vecs[NVEC];
  bit   expKey[$];
  bit   actKey[$];
  int   checkCount;
  int   passCount;

  morse_tx_sequencer #(
    .UNIT_CYCLES      (UNIT),
    .WORD_EXTRA_UNITS (WORDX)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ascii_data  (ascii_data),
    .ascii_valid (ascii_valid),
    .ascii_ready (ascii_ready),
    .key_out     (key_out),
    .busy        (busy),
    .char_done   (char_done)
`ifdef MORSE_ABORT_EN
    ,
    .abort       (abort)
`endif
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checkCount++;
    if (actual == expected) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  task automatic setVec(input int idx, input logic [7:0] ch, input string s, input int expDone);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < s.len(); i++) p = {p[55:0], s[i]};
    vecs[idx].ch      = ch;
    vecs[idx].pat     = p;
    vecs[idx].expDone = expDone;
  endtask

  // Expected key samples starting one clock after the accept edge
  task automatic buildExpected(input logic [63:0] pat);
    logic [7:0] c;
    int nEl;
    int seen;
    expKey.delete();
    expKey.push_back(1'b0);
    nEl = 0;
    for (int b = 7; b >= 0; b--) begin
      c = pat[b*8 +: 8];
      if (c == 8'h2E || c == 8'h2D) nEl++;
    end
    if (nEl == 0) begin
      repeat (WORDX * UNIT) expKey.push_back(1'b0);
    end else begin
      seen = 0;
      for (int b = 7; b >= 0; b--) begin
        c = pat[b*8 +: 8];
        if (c == 8'h2E || c == 8'h2D) begin
          repeat ((c == 8'h2D) ? 3 * UNIT : UNIT) expKey.push_back(1'b1);
          seen++;
          if (seen < nEl) repeat (UNIT) expKey.push_back(1'b0);
        end
      end
      repeat (3 * UNIT) expKey.push_back(1'b0);
    end
  endtask

  // Present one character; returns just after the accept edge
  task automatic applyStimulus(input logic [7:0] ch);
    @(negedge clk);
    ascii_data  = ch;
    ascii_valid = 1'b1;
    @(posedge clk);
    #1;
    ascii_valid = 1'b0;
  endtask

  task automatic runVector(input vec_t v);
    bit busyOk;
    bit done;
    int firstBad;
    int n;
    buildExpected(v.pat);
    actKey.delete();
    applyStimulus(v.ch);
    busyOk = 1'b1;
    done   = 1'b0;
    for (int k = 1; k <= 300 && !done; k++) begin
      @(posedge clk);
      #1;
      actKey.push_back(key_out);
      if (char_done) done = 1'b1;
      else if (!busy) busyOk = 1'b0;
    end
    n = actKey.size();
    checkOutput($sformatf("char_done latency ch=%h", v.ch), done ? n : -1, v.expDone);
    firstBad = -1;
    for (int i = 0; i < n && i < expKey.size(); i++)
      if (firstBad < 0 && actKey[i] != expKey[i]) firstBad = i;
    if (firstBad < 0 && n != expKey.size()) firstBad = (n < expKey.size()) ? n : expKey.size();
    checkOutput($sformatf("key pattern first bad sample ch=%h", v.ch), firstBad, -1);
    checkOutput($sformatf("busy while sending ch=%h", v.ch), int'(busyOk), 1);
    checkOutput($sformatf("ready/busy/key after done ch=%h", v.ch), int'({ascii_ready, busy, key_out}), 4);
    @(posedge clk);
    #1;
    checkOutput($sformatf("char_done single pulse ch=%h", v.ch), int'(char_done), 0);
  endtask

  // Stream characters with ascii_valid held high; measures the key-off span
  // between the first and second keyed elements of the stream
  task automatic runStream(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                           input int nCh, input int expGap, input string name);
    int sent;
    int phase;
    int offRun;
    int gap;
    int dones;
    logic rdyBefore;
    sent = 0; phase = 0; offRun = 0; gap = -1; dones = 0;
    @(negedge clk);
    ascii_data  = c0;
    ascii_valid = 1'b1;
    for (int k = 0; k < 600; k++) begin
      rdyBefore = ascii_ready;
      @(posedge clk);
      #1;
      if (char_done) dones++;
      if (rdyBefore && ascii_valid) begin
        sent++;
        if (sent == 1) ascii_data = c1;
        else if (sent == 2) ascii_data = c2;
        if (sent >= nCh) ascii_valid = 1'b0;
      end
      if (phase == 0 && key_out) phase = 1;
      else if (phase == 1 && !key_out) begin phase = 2; offRun = 1; end
      else if (phase == 2) begin
        if (key_out) begin gap = offRun; phase = 3; end
        else offRun++;
      end
      if (dones == nCh) break;
      @(negedge clk);
    end
    ascii_valid = 1'b0;
    checkOutput({name, " key-off gap"}, gap, expGap);
    checkOutput({name, " chars accepted"}, sent, nCh);
    checkOutput({name, " char_done pulses"}, dones, nCh);
    checkOutput({name, " ready at end"}, int'(ascii_ready), 1);
  endtask

  task automatic runResetMidChar();
    bit seen;
    bit done;
    bit keyOn;
    seen = 1'b0;
    applyStimulus(8'h54);
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (key_out) seen = 1'b1;
    end
    checkOutput("reset test dash started", int'(seen), 1);
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async reset drops key", int'(key_out), 0);
    checkOutput("reset busy/ready", int'({busy, ascii_ready}), 1);
    @(negedge clk);
    rst_n = 1'b1;
    done = 1'b0; keyOn = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (char_done) done = 1'b1;
      if (key_out) keyOn = 1'b1;
    end
    checkOutput("no char_done after reset", int'(done), 0);
    checkOutput("key idle after reset", int'(keyOn), 0);
    checkOutput("idle after reset", int'({busy, ascii_ready}), 1);
  endtask

`ifdef MORSE_ABORT_EN
  task automatic runAbort();
    int phase;
    int cnt;
    bit done;
    bit keyOn;
    phase = 0;
    applyStimulus(8'h42);
    for (int k = 0; k < 200 && phase < 3; k++) begin
      @(posedge clk);
      #1;
      if (phase == 0 && key_out) phase = 1;
      else if (phase == 1 && !key_out) phase = 2;
      else if (phase == 2 && key_out) phase = 3;
    end
    checkOutput("abort second element reached", phase, 3);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("abort drops key", int'(key_out), 0);
    cnt = 0; done = 1'b0; keyOn = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(posedge clk);
      #1;
      cnt++;
      if (key_out) keyOn = 1'b1;
      if (char_done) done = 1'b1;
    end
    checkOutput("abort clocks to char_done", done ? cnt : -1, 3 * UNIT);
    checkOutput("abort key stays off", int'(keyOn), 0);
  endtask
`endif

  initial begin
    checkCount  = 0;
    passCount   = 0;
    rst_n       = 1'b0;
    ascii_data  = 8'h00;
    ascii_valid = 1'b0;
`ifdef MORSE_ABORT_EN
    abort       = 1'b0;
`endif

    // {char, expected Morse, clocks from accept edge to char_done}
    setVec(0,  8'h45, ".",        17);
    setVec(1,  8'h41, ".-",       33);
    setVec(2,  8'h61, ".-",       33);
    setVec(3,  8'h54, "-",        25);
    setVec(4,  8'h20, " ",        17);
    setVec(5,  8'h7E, "........", 73);
    setVec(6,  8'h53, "...",      33);
    setVec(7,  8'h35, ".....",    49);
    setVec(8,  8'h7A, "--..",     57);
    setVec(9,  8'h30, "-----",    89);
    setVec(10, 8'h42, "-...",     49);
    setVec(11, 8'h6B, "-.-",      49);

    repeat (2) @(negedge clk);
    checkOutput("reset key_out", int'(key_out), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset char_done", int'(char_done), 0);
    checkOutput("reset ascii_ready", int'(ascii_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < NVEC; i++) runVector(vecs[i]);

    runStream(8'h45, 8'h45, 8'h00, 2, 3 * UNIT + 2, "E,E");
    runStream(8'h45, 8'h20, 8'h54, 3, 7 * UNIT + 4, "E,space,T");

    runResetMidChar();
    runVector(vecs[0]);

`ifdef MORSE_ABORT_EN
    runAbort();
    runVector(vecs[0]);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
